// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded-field requests into RV64I words and streams
// them out of a small FIFO with an auto-incrementing address.
// Optional feature macro: INST_ENC_RANGE_CHECK_EN (immediate range check).
module inst_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_op,
    input  logic [4:0]                 req_rd,
    input  logic [4:0]                 req_rs1,
    input  logic [4:0]                 req_rs2,
    input  logic [31:0]                req_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [63:0]                out_addr,
    output logic                       err,
    output logic [7:0]                 err_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_ADDI  = 4'd2;
    localparam logic [3:0] OP_SLTIU = 4'd3;
    localparam logic [3:0] OP_ADDW  = 4'd4;
    localparam logic [3:0] OP_LW    = 4'd5;
    localparam logic [3:0] OP_SD    = 4'd6;
    localparam logic [3:0] OP_JAL   = 4'd7;
    localparam logic [3:0] OP_LUI   = 4'd8;
    localparam logic [3:0] OP_AUIPC = 4'd9;
    localparam logic [3:0] OP_JALR  = 4'd10;
    localparam logic [3:0] OP_BEQ   = 4'd11;
    localparam logic [3:0] OP_BNE   = 4'd12;
    localparam logic [3:0] OP_EBRK  = 4'd13;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_R32  = 7'b0111011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_ST   = 7'b0100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_AUI  = 7'b0010111;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [63:0]   addr_q;
    logic          err_q;
    logic [7:0]    cnt_q;

    logic [31:0]   enc;
    logic          legal;
    logic          rng_ok;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          reject;
    logic          unused_imm;

    logic [31:0] im;
    assign im = req_imm;

    assign unused_imm = ^{im[31:21], im[0]};

    // Combinational encoder from request fields
    always_comb begin
        enc   = '0;
        legal = 1'b1;
        unique case (req_op)
            OP_ADD:   enc = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, OPC_R};
            OP_SUB:   enc = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, OPC_R};
            OP_ADDW:  enc = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, OPC_R32};
            OP_ADDI:  enc = {im[11:0], req_rs1, 3'b000, req_rd, OPC_IMM};
            OP_SLTIU: enc = {im[11:0], req_rs1, 3'b011, req_rd, OPC_IMM};
            OP_LW:    enc = {im[11:0], req_rs1, 3'b010, req_rd, OPC_LD};
            OP_JALR:  enc = {im[11:0], req_rs1, 3'b000, req_rd, OPC_JALR};
            OP_SD:    enc = {im[11:5], req_rs2, req_rs1, 3'b011, im[4:0], OPC_ST};
            OP_BEQ:   enc = {im[12], im[10:5], req_rs2, req_rs1, 3'b000,
                             im[4:1], im[11], OPC_BR};
            OP_BNE:   enc = {im[12], im[10:5], req_rs2, req_rs1, 3'b001,
                             im[4:1], im[11], OPC_BR};
            OP_JAL:   enc = {im[20], im[10:1], im[11], im[19:12], req_rd, OPC_JAL};
            OP_LUI:   enc = {im[19:0], req_rd, OPC_LUI};
            OP_AUIPC: enc = {im[19:0], req_rd, OPC_AUI};
            OP_EBRK:  enc = 32'h0010_0073;
            default:  legal = 1'b0;
        endcase
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    logic i_ok;
    logic b_ok;
    logic j_ok;
    logic u_ok;

    assign i_ok = (&im[31:11]) | ~(|im[31:11]);
    assign b_ok = ((&im[31:12]) | ~(|im[31:12])) & ~im[0];
    assign j_ok = ((&im[31:20]) | ~(|im[31:20])) & ~im[0];
    assign u_ok = ~(|im[31:20]);

    // Per-format immediate range selection
    always_comb begin
        rng_ok = 1'b1;
        unique case (req_op)
            OP_ADDI, OP_SLTIU, OP_LW,
            OP_JALR, OP_SD:         rng_ok = i_ok;
            OP_BEQ, OP_BNE:         rng_ok = b_ok;
            OP_JAL:                 rng_ok = j_ok;
            OP_LUI, OP_AUIPC:       rng_ok = u_ok;
            default:                rng_ok = 1'b1;
        endcase
    end
`else
    assign rng_ok = 1'b1;
`endif

    assign full      = (count == FULL_LVL);
    assign empty     = (count == '0);
    assign req_ready = !full || out_ready;
    assign accept    = req_valid && req_ready;
    assign push      = accept && legal && rng_ok;
    assign reject    = accept && !(legal && rng_ok);
    assign pop       = !empty && out_ready;

    assign out_valid = !empty;
    assign out_inst  = empty ? 32'h0 : mem[rd_ptr];
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign err_cnt   = cnt_q;
    assign level     = count;

    // FIFO storage, pointers, address counter and error tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            addr_q <= BASE_ADDR;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr_q <= addr_q + 64'd4;
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (reject) begin
                err_q <= 1'b1;
                if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: randomized and directed checks of inst_encoder
// against a queue-based reference model.
module tb_inst_encoder;

    localparam int          DEPTH = 4;
    localparam int          LW    = $clog2(DEPTH) + 1;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [4:0]    req_rd;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [31:0]   req_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [63:0]   out_addr;
    logic          err;
    logic [7:0]    err_cnt;
    logic [LW-1:0] level;

    inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .err(err), .err_cnt(err_cnt), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    logic [63:0] m_addr;
    bit          m_err;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint fld(input logic [31:0] v, input int lo,
                                   input int n);
        return longint'((v >> lo) & ((32'd1 << n) - 32'd1));
    endfunction

    function automatic logic [31:0] ref_enc(input int op, input int rd,
        input int rs1, input int rs2, input logic [31:0] imm);
        longint w;
        longint b20, b15, b12, b7;
        b20 = 64'd1 << 20; b15 = 64'd1 << 15;
        b12 = 64'd1 << 12; b7 = 64'd1 << 7;
        w = 0;
        case (op)
            0:  w = rs2*b20 + rs1*b15 + rd*b7 + 'h33;
            1:  w = 'h20*(64'd1 << 25) + rs2*b20 + rs1*b15 + rd*b7 + 'h33;
            4:  w = rs2*b20 + rs1*b15 + rd*b7 + 'h3B;
            2:  w = fld(imm,0,12)*b20 + rs1*b15 + rd*b7 + 'h13;
            3:  w = fld(imm,0,12)*b20 + rs1*b15 + 3*b12 + rd*b7 + 'h13;
            5:  w = fld(imm,0,12)*b20 + rs1*b15 + 2*b12 + rd*b7 + 'h03;
            10: w = fld(imm,0,12)*b20 + rs1*b15 + rd*b7 + 'h67;
            6:  w = fld(imm,5,7)*(64'd1 << 25) + rs2*b20 + rs1*b15
                    + 3*b12 + fld(imm,0,5)*b7 + 'h23;
            11, 12:
                w = fld(imm,12,1)*(64'd1 << 31) + fld(imm,5,6)*(64'd1 << 25)
                    + rs2*b20 + rs1*b15 + (op - 11)*b12
                    + fld(imm,1,4)*(64'd1 << 8) + fld(imm,11,1)*b7 + 'h63;
            7:  w = fld(imm,20,1)*(64'd1 << 31) + fld(imm,1,10)*(64'd1 << 21)
                    + fld(imm,11,1)*b20 + fld(imm,12,8)*b12 + rd*b7 + 'h6F;
            8:  w = fld(imm,0,20)*b12 + rd*b7 + 'h37;
            9:  w = fld(imm,0,20)*b12 + rd*b7 + 'h17;
            13: w = 'h00100073;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    function automatic bit rng_ok(input int op, input logic [31:0] imm);
`ifdef INST_ENC_RANGE_CHECK_EN
        int s;
        s = $signed(imm);
        case (op)
            2, 3, 5, 6, 10: return s >= -2048 && s <= 2047;
            11, 12: return s >= -4096 && s <= 4094 && (s % 2) == 0;
            7: return s >= -1048576 && s <= 1048574 && (s % 2) == 0;
            8, 9: return imm < 32'h0010_0000;
            default: return 1'b1;
        endcase
`else
        return (op >= 0);
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_addr = BASE;
        m_err  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic check_state();
        chk("out_valid", out_valid, q.size() > 0);
        chk("level", level, q.size());
        chk("out_inst", out_inst, q.size() > 0 ? q[0] : 32'h0);
        chk("out_addr", out_addr, m_addr);
        chk("err", err, m_err);
        chk("err_cnt", err_cnt, m_cnt);
    endtask

    // Called just after a falling edge; returns at the next falling edge
    task automatic cycle(input bit v, input int op, input int rd,
        input int rs1, input int rs2, input logic [31:0] imm,
        input bit ordy);
        bit mready;
        bit popm;
        bit acc;
        req_valid = v;
        req_op    = op[3:0];
        req_rd    = rd[4:0];
        req_rs1   = rs1[4:0];
        req_rs2   = rs2[4:0];
        req_imm   = imm;
        out_ready = ordy;
        mready = (q.size() < DEPTH) || ordy;
        popm   = (q.size() > 0) && ordy;
        acc    = v && mready;
        #1;
        chk("req_ready", req_ready, mready);
        if (popm) begin
            void'(q.pop_front());
            m_addr += 64'd4;
        end
        if (acc) begin
            if (op < 14 && rng_ok(op, imm))
                q.push_back(ref_enc(op, rd, rs1, rs2, imm));
            else begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 0, 0, 0, 0, 32'h0, ordy);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        chk("drained", out_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0;
        req_rs2 = '0; req_imm = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        check_state();
        rst_n = 1'b1;

        // ADDI rd=1 rs1=0 imm=5, visible one cycle later
        cycle(1'b1, 2, 1, 0, 0, 32'd5, 1'b0);
        chk("addi_inst", out_inst, 32'h0050_0093);
        chk("addi_addr", out_addr, 64'h8000_0000);
        idle(1'b1);

        // LUI then BNE
        cycle(1'b1, 8, 5, 0, 0, 32'h12345, 1'b0);
        cycle(1'b1, 12, 0, 1, 2, -32'sd4, 1'b0);
        chk("lui_inst", out_inst, 32'h1234_52B7);
        chk("lui_addr", out_addr, 64'h8000_0004);
        idle(1'b1);
        chk("bne_inst", out_inst, 32'hFE20_9EE3);
        chk("bne_addr", out_addr, 64'h8000_0008);
        drain();

        // Fill past DEPTH with sink stalled, then push/pop at full
        for (int i = 0; i <= DEPTH; i++)
            cycle(1'b1, 2, i + 1, 0, 0, i, 1'b0);
        chk("full_level", level, DEPTH);
        chk("full_ready", req_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 0, 7, i, i + 1, 0, 1'b1);
            chk("pp_level", level, DEPTH);
        end
        drain();

        // Illegal op then EBREAK
        cycle(1'b1, 14, 3, 3, 3, 32'h55, 1'b1);
        cycle(1'b1, 13, 3, 3, 3, 32'h55, 1'b1);
        chk("ill_err", err, 1'b1);
        chk("ill_cnt", err_cnt, 8'd1);
        chk("ebreak", out_inst, 32'h0010_0073);
        drain();

        // Asynchronous reset with three words buffered
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 0, i + 1, 1, 2, 0, 1'b0);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_level", level, 0);
        chk("arst_addr", out_addr, 64'h8000_0000);
        chk("arst_err", err, 1'b0);
        chk("arst_cnt", err_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_state();

        // ADDI imm=2048 boundary
        cycle(1'b1, 2, 1, 0, 0, 32'd2048, 1'b0);
`ifdef INST_ENC_RANGE_CHECK_EN
        chk("imm2048_cnt", err_cnt, 8'd1);
        chk("imm2048_drop", out_valid, 1'b0);
`else
        chk("imm2048_inst", out_inst, 32'h8000_0093);
        chk("imm2048_err", err, 1'b0);
`endif
        drain();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            int op;
            logic [31:0] imm;
            int sel;
            op  = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 15)
                                               : $urandom_range(0, 13);
            sel = $urandom_range(0, 3);
            if (sel == 0)      imm = $urandom;
            else if (sel == 1) imm = $urandom_range(0, 8191) - 4096;
            else if (sel == 2) imm = $urandom_range(0, 32'h1F_FFFF) - 32'h10_0000;
            else               imm = $urandom_range(0, 32'hF_FFFF);
            cycle($urandom_range(0, 3) != 0, op, $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), imm,
                  $urandom_range(0, 2) != 0);
        end
        drain();

        // Error counter saturation
        for (int i = 0; i < 260; i++)
            cycle(1'b1, 15, 0, 0, 0, 0, 1'b1);
        chk("cnt_sat", err_cnt, 8'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
